// File: rtl/io_map_pkg.sv
// Shared address map, device enum and posted-write entry type for the MMIO write bridge.
package io_map_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFF_W  = 3;

  localparam logic [31:0] TIMER_BASE_DEF = 32'h0000_7F00;
  localparam logic [31:0] TUBE_BASE_DEF  = 32'h0000_7F20;
  localparam logic [31:0] SW_BASE_DEF    = 32'h0000_7F40;

  // Window sizes in bytes: timer 3 words, tube 5 words, switch 2 words
  localparam logic [31:0] TIMER_SPAN = 32'd12;
  localparam logic [31:0] TUBE_SPAN  = 32'd20;
  localparam logic [31:0] SW_SPAN    = 32'd8;

  typedef enum logic [1:0] {
    DEV_NONE  = 2'd0,
    DEV_TIMER = 2'd1,
    DEV_TUBE  = 2'd2,
    DEV_SW    = 2'd3
  } dev_e;

  typedef struct packed {
    dev_e              dev;
    logic [OFF_W-1:0]  off;
    logic [DATA_W-1:0] data;
  } wentry_t;

  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] span);
    return (addr >= base) && (addr < (base + span));
  endfunction

endpackage

// File: rtl/iob_wfifo.sv
// Posted-write FIFO of wentry_t; head entry is read combinationally.
module iob_wfifo
  import io_map_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic          pop,
  input  wentry_t       wdata,
  output wentry_t       head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  wentry_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_write_bridge.sv
// CPU MMIO bridge: decodes accesses, posts stores through iob_wfifo and drains them in order.
// Optional same-cycle write bypass on an empty FIFO is enabled by defining IOB_BYPASS_EN.
module io_write_bridge
  import io_map_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] TIMER_BASE = TIMER_BASE_DEF,
  parameter logic [31:0] TUBE_BASE  = TUBE_BASE_DEF,
  parameter logic [31:0] SW_BASE    = SW_BASE_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       PrAddr,
  input  logic [DATA_W-1:0] PrWD,
  input  logic              PrWE,
  input  logic              PrRE,
  output logic [DATA_W-1:0] PrRD,
  output logic              PrStall,
  output logic [OFF_W-1:0]  DevAddr,
  output logic [DATA_W-1:0] DevWD,
  output logic              WeTimer,
  output logic              WeTube,
  output logic              WeSw,
  input  logic              DevReady,
  input  logic [DATA_W-1:0] RdTimer,
  input  logic [DATA_W-1:0] RdTube,
  input  logic [DATA_W-1:0] RdSw
);

  localparam int unsigned FIFO_CW = $clog2(FIFO_DEPTH) + 1;

  dev_e               pr_dev;
  logic [OFF_W-1:0]   pr_off;
  logic               mapped;
  logic               rd_only;
  logic               bypass;
  logic               full_stall;
  logic               rd_stall;
  logic               push;
  logic               pop;
  wentry_t            push_entry;
  wentry_t            head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FIFO_CW-1:0] fifo_count;

  // Address decode into device select and word offset
  always_comb begin
    pr_dev = DEV_NONE;
    pr_off = '0;
    if (in_window(PrAddr, TIMER_BASE, TIMER_SPAN)) begin
      pr_dev = DEV_TIMER;
      pr_off = OFF_W'((PrAddr - TIMER_BASE) >> 2);
    end else if (in_window(PrAddr, TUBE_BASE, TUBE_SPAN)) begin
      pr_dev = DEV_TUBE;
      pr_off = OFF_W'((PrAddr - TUBE_BASE) >> 2);
    end else if (in_window(PrAddr, SW_BASE, SW_SPAN)) begin
      pr_dev = DEV_SW;
      pr_off = OFF_W'((PrAddr - SW_BASE) >> 2);
    end
  end

  assign mapped  = (pr_dev != DEV_NONE);
  assign rd_only = PrRE & ~PrWE;

`ifdef IOB_BYPASS_EN
  assign bypass = PrWE & mapped & fifo_empty & DevReady;
`else
  assign bypass = 1'b0;
`endif

  // Full stall is conservative: a same-cycle pop does not release it
  assign full_stall = PrWE & mapped & fifo_full;
  assign rd_stall   = rd_only & (fifo_count != '0);
  assign PrStall    = full_stall | rd_stall;

  assign push       = PrWE & mapped & ~PrStall & ~bypass;
  assign pop        = ~fifo_empty & DevReady;
  assign push_entry = '{dev: pr_dev, off: pr_off, data: PrWD};

  iob_wfifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Device-side mux: FIFO head has priority, then the bypassed CPU store
  always_comb begin
    DevAddr = pr_off;
    DevWD   = '0;
    WeTimer = 1'b0;
    WeTube  = 1'b0;
    WeSw    = 1'b0;
    if (!fifo_empty) begin
      DevAddr = head.off;
      DevWD   = head.data;
      WeTimer = (head.dev == DEV_TIMER);
      WeTube  = (head.dev == DEV_TUBE);
      WeSw    = (head.dev == DEV_SW);
    end else if (bypass) begin
      DevWD   = PrWD;
      WeTimer = (pr_dev == DEV_TIMER);
      WeTube  = (pr_dev == DEV_TUBE);
      WeSw    = (pr_dev == DEV_SW);
    end
  end

  // Read data only once all posted writes have drained
  always_comb begin
    PrRD = '0;
    if (rd_only && fifo_empty) begin
      unique case (pr_dev)
        DEV_TIMER: PrRD = RdTimer;
        DEV_TUBE:  PrRD = RdTube;
        DEV_SW:    PrRD = RdSw;
        default:   PrRD = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_write_bridge.sv
// Directed and randomized checks of io_write_bridge against a queue-based model of the bridge.
module tb_io_write_bridge;

  localparam int DEPTH = 4;

  logic        CLK;
  logic        RST;
  logic [31:0] PrAddr;
  logic [31:0] PrWD;
  logic        PrWE;
  logic        PrRE;
  logic [31:0] PrRD;
  logic        PrStall;
  logic [2:0]  DevAddr;
  logic [31:0] DevWD;
  logic        WeTimer;
  logic        WeTube;
  logic        WeSw;
  logic        DevReady;
  logic [31:0] RdTimer;
  logic [31:0] RdTube;
  logic [31:0] RdSw;

  int total;
  int bad;

  typedef struct {
    int          dev;
    int          off;
    logic [31:0] data;
  } ment_t;

  ment_t q[$];

  io_write_bridge #(.FIFO_DEPTH(DEPTH)) u_dut (
    .CLK      (CLK),
    .RST      (RST),
    .PrAddr   (PrAddr),
    .PrWD     (PrWD),
    .PrWE     (PrWE),
    .PrRE     (PrRE),
    .PrRD     (PrRD),
    .PrStall  (PrStall),
    .DevAddr  (DevAddr),
    .DevWD    (DevWD),
    .WeTimer  (WeTimer),
    .WeTube   (WeTube),
    .WeSw     (WeSw),
    .DevReady (DevReady),
    .RdTimer  (RdTimer),
    .RdTube   (RdTube),
    .RdSw     (RdSw)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Device number: 0 unmapped, 1 timer, 2 tube, 3 switch
  function automatic int dec_dev(input logic [31:0] a);
    if (a >= 32'h7F00 && a < 32'h7F0C) return 1;
    if (a >= 32'h7F20 && a < 32'h7F34) return 2;
    if (a >= 32'h7F40 && a < 32'h7F48) return 3;
    return 0;
  endfunction

  function automatic int dec_off(input logic [31:0] a);
    case (dec_dev(a))
      1:       return int'((a - 32'h7F00) / 4);
      2:       return int'((a - 32'h7F20) / 4);
      3:       return int'((a - 32'h7F40) / 4);
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; PrWE = 1'b0; PrRE = 1'b0; PrAddr = '0; PrWD = '0; DevReady = 1'b0;
    @(posedge CLK);
    q.delete();
  endtask

  // One CPU cycle: drive, check outputs against the model, then advance the model
  task automatic step(input logic we, input logic re, input logic [31:0] addr,
                      input logic [31:0] wd, input logic rdy);
    int n, d, off, exp_dev, exp_addr;
    logic exp_stall, byp;
    logic [31:0] exp_wd, exp_rd;
    @(negedge CLK);
    RST = 1'b0; PrWE = we; PrRE = re; PrAddr = addr; PrWD = wd; DevReady = rdy;
    RdTimer = $urandom; RdTube = $urandom; RdSw = $urandom;
    #1;
    n   = q.size();
    d   = dec_dev(addr);
    off = dec_off(addr);
    exp_stall = (we && d != 0 && n == DEPTH) || (re && !we && n != 0);
    byp = 1'b0;
`ifdef IOB_BYPASS_EN
    byp = we && d != 0 && n == 0 && rdy;
`endif
    exp_dev = 0; exp_addr = off; exp_wd = '0;
    if (n != 0) begin
      exp_dev = q[0].dev; exp_addr = q[0].off; exp_wd = q[0].data;
    end else if (byp) begin
      exp_dev = d; exp_wd = wd;
    end
    exp_rd = '0;
    if (re && !we && n == 0) begin
      if (d == 1) exp_rd = RdTimer;
      if (d == 2) exp_rd = RdTube;
      if (d == 3) exp_rd = RdSw;
    end
    chk("count",   32'(u_dut.fifo_count), 32'(n));
    chk("stall",   32'(PrStall), 32'(exp_stall));
    chk("we_timer", 32'(WeTimer), 32'(exp_dev == 1));
    chk("we_tube",  32'(WeTube),  32'(exp_dev == 2));
    chk("we_sw",    32'(WeSw),    32'(exp_dev == 3));
    chk("dev_wd",  DevWD, exp_wd);
    chk("pr_rd",   PrRD, exp_rd);
    if (n != 0 || d != 0) chk("dev_addr", 32'(DevAddr), 32'(exp_addr));
    if (n != 0 && rdy) void'(q.pop_front());
    if (we && d != 0 && !exp_stall && !byp) q.push_back('{dev: d, off: off, data: wd});
    @(posedge CLK);
  endtask

  initial begin
    logic [31:0] a;
    total = 0; bad = 0;
    RST = 1'b1; PrWE = 1'b0; PrRE = 1'b0; PrAddr = '0; PrWD = '0; DevReady = 1'b0;
    RdTimer = '0; RdTube = '0; RdSw = '0;
    repeat (2) @(posedge CLK);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Single tube store, visible at the head one cycle later
    step(1'b1, 1'b0, 32'h7F20, 32'h1234_5678, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Fill to full with devices busy, then drain in order
    step(1'b1, 1'b0, 32'h7F24, 32'h11, 1'b0);
    step(1'b1, 1'b0, 32'h7F28, 32'h22, 1'b0);
    step(1'b1, 1'b0, 32'h7F2C, 32'h33, 1'b0);
    step(1'b1, 1'b0, 32'h7F30, 32'h44, 1'b0);
    step(1'b1, 1'b0, 32'h7F04, 32'h55, 1'b0);
    step(1'b1, 1'b0, 32'h7F04, 32'h55, 1'b1);
    step(1'b1, 1'b0, 32'h7F04, 32'h55, 1'b1);
    repeat (5) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Read held off behind a pending write
    step(1'b1, 1'b0, 32'h7F30, 32'hA5, 1'b1);
    step(1'b0, 1'b1, 32'h7F30, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h7F30, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h7F30, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h7F30, 32'h0, 1'b1);

    // Unmapped accesses, window edges, and simultaneous store/load
    step(1'b1, 1'b0, 32'h7F80, 32'hDEAD, 1'b1);
    step(1'b0, 1'b1, 32'h7F80, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h7F0C, 32'h1, 1'b1);
    step(1'b0, 1'b1, 32'h7F0B, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h7F47, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h7F44, 32'h99, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

`ifdef IOB_BYPASS_EN
    step(1'b1, 1'b0, 32'h7F40, 32'h7, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
`endif

    // Reset in the middle of a burst discards pending writes
    step(1'b1, 1'b0, 32'h7F20, 32'hA, 1'b0);
    step(1'b1, 1'b0, 32'h7F24, 32'hB, 1'b0);
    step(1'b1, 1'b0, 32'h7F08, 32'hC, 1'b0);
    do_reset();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0:       a = 32'h7F00 + 32'($urandom_range(0, 3)) * 4;
        1:       a = 32'h7F20 + 32'($urandom_range(0, 5)) * 4;
        2:       a = 32'h7F40 + 32'($urandom_range(0, 2)) * 4;
        3:       a = 32'h7EF0 + 32'($urandom_range(0, 32)) * 4;
        default: a = $urandom;
      endcase
      a[1:0] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) do_reset();
      step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0), a, $urandom,
           1'($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
